pipe_stage_reg: RTL

Parametrised pipeline stage register for the MIPS datapath. It replaces bare edge-triggered storage between pipeline stages with a registered valid/ready stage that holds two entries: a main register and a skid register. Upstream can keep issuing while downstream stalls, with no combinational path from `out_ready` to `in_ready`. A synchronous flush supports branch/jump squashing.

---
 rtl/pipe_stage_reg.sv | 89 ++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Two-entry valid/ready pipeline stage: a main register feeding out_data and a
// skid register that absorbs one extra beat while downstream stalls.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             take;

  // Handshake flags come only from the state register, so out_ready never
  // reaches in_ready combinationally.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign count     = state_q;
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            main_d  = in_data;
          end
        end
        HALF: begin
          if (accept && take) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // Skid entry is always the younger one; it moves up on a take.
          if (take) begin
            state_d = HALF;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
